lfsr_key_sequencer: RTL and testbench
=====================================

# lfsr_key_sequencer

Sits directly downstream of the LFSR address generator and owns its `enable`. Each enabled cycle it samples the LFSR output and discards indices at or above the key count; the power-of-two mask lets such indices through. It forwards in-range indices to the key-fetch/update engine over a valid/ready handshake. It terminates a sweep after exactly `num_keys` indices have been issued, or after an attempt limit.

## Interface
- `ADDR_WIDTH`, 8, width of issued key index
- `MAX_ADDR_VAL`, 256, largest legal key count; `num_keys` is clamped to this
- `ATTEMPT_LIMIT`, 65536, maximum LFSR-enabled cycles per sweep before abort

- `clk` in 1: the single clock
- `reset` in 1: asynchronous, active-high
- `start` in 1: single-cycle sweep request; ignored unless `busy`=0
- `num_keys` in 32: key count for the sweep, sampled on accepted `start`
- `lfsr_out` in 32: current LFSR value
- `lfsr_enable` out 1: advance request to the LFSR
- `lfsr_num_keys` out 32: registered key count driven to the LFSR, stable for the whole sweep
- `key_valid` out 1: `key_index` is valid
- `key_ready` in 1: the consumer accepts the index
- `key_index` out ADDR_WIDTH: issued key index
- `busy` out 1: a sweep is in progress
- `done` out 1: one-cycle pulse at sweep end
- `timeout` out 1: sticky flag, set when a sweep aborts; cleared by the next accepted `start`
- `issued_count` out 32: number of indices handed off in the current or last sweep

## Operation
- Reset values: all outputs 0, state IDLE, all counters and registers 0.
- **States:**
  - IDLE: `start`=1 latches `nk_q = min(num_keys, MAX_ADDR_VAL)`, clears the counters and `timeout`, and moves to RUN. If `nk_q`=0, moves to FIN instead.
  - RUN: issues indices; moves to DRAIN on the final issue or on timeout.
  - DRAIN: waits until `key_valid`=0 or the final handshake completes, then moves to FIN.
  - FIN: `done`=1 for one cycle, then IDLE.
- `busy` is 1 in RUN, DRAIN and FIN.
- `lfsr_enable` = (state==RUN) && (!`key_valid` || `key_ready`) && (`sel_count` < `nk_q`) && (`attempts` < `ATTEMPT_LIMIT`).
- **Sampling:** in any cycle with `lfsr_enable`=1, `lfsr_out` (the pre-advance value) is sampled, and `attempts` increments.
  - If `lfsr_out` < `nk_q`: load `key_index` = `lfsr_out[ADDR_WIDTH-1:0]`, set `key_valid`=1, increment `sel_count`.
  - Otherwise: discard the value; `key_valid` clears if it was consumed this cycle.
- **Handshake:** one output register. `key_valid` and `key_index` hold until `key_ready`. `issued_count` increments on each `key_valid && key_ready`. Load and consume in the same cycle are permitted, giving a throughput of one index per clock.
- **Sweep end:** when `sel_count` reaches `nk_q`, `lfsr_enable` drops to 0 from the following cycle.
- **Timeout:** when `attempts` reaches `ATTEMPT_LIMIT` with `sel_count` < `nk_q`, set `timeout`=1 and go to DRAIN. Any held index is still delivered.
- **Duplicates:** duplicate indices, including the LFSR pause value 1, are forwarded unchanged. Exactly `nk_q` issues per sweep is guaranteed; uniqueness is not.
- `num_keys` changes during a sweep have no effect. `start` while busy is ignored.
- A `reset` mid-sweep returns the block to IDLE with all outputs 0. No `done` pulse is produced.
- Counter width is 32 bits; counters saturate, with no wrap within the legal range.

## Timing
- `start` is accepted at edge 0. In cycle 1, state is RUN and `lfsr_enable`=1.
- An in-range sample in cycle 1 gives `key_valid`=1 in cycle 2.
- The final handshake at edge N gives FIN, and `done`=1 in cycle N+1.
- `num_keys`=0: `start` at edge 0 gives `done` in cycle 1 with no `lfsr_enable`.
- `key_ready` low stalls `lfsr_enable` combinationally in the same cycle, so no samples are lost.

## Structure
- Shared package holds:
  - the state encoding (IDLE, RUN, DRAIN, FIN)
  - the default `ATTEMPT_LIMIT`
  - the 32-bit count type, shared with the LFSR block
- Natural sub-module: `key_out_reg`, a one-entry valid/ready output register with load/consume logic. The FSM and filter stay in the top module.

## Test plan
- `num_keys`=5, LFSR model yields 0,1,2,3,4,5,6,7,…, `key_ready`=1: issues 0,1,2,3,4; 6 attempts or fewer; `done` one cycle after the fifth handshake; `issued_count`=5.
- `num_keys`=5, LFSR values 7,6,5,2,… interleaved: 7, 6 and 5 are never issued; exactly 5 issues occur; `lfsr_enable` drops after the fifth selection.
- `key_ready` held 0 for 10 cycles after the first valid: `key_index` stable, `lfsr_enable`=0 throughout, the LFSR does not advance, and the sequence resumes unchanged.
- `num_keys`=300 with `MAX_ADDR_VAL`=256: `lfsr_num_keys`=256 and exactly 256 issues; `num_keys`=0 gives `done` in cycle 1 with zero issues.
- `ATTEMPT_LIMIT`=16, LFSR stuck at 200 with `num_keys`=10: 16 attempts, then `timeout`=1 and `done` pulses; the next `start` clears `timeout`.
- `reset` asserted mid-sweep with `key_valid`=1: asynchronous clear of all outputs, no `done` pulse; a fresh `start` then works normally.

Source files
------------

// File: rtl/lfsr_key_sequencer_pkg.sv
// Shared definitions for the key sequencer: FSM encoding, count type and
// default limits, plus a saturating increment used by every counter.
package lfsr_key_sequencer_pkg;

    typedef logic [31:0] count_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } state_e;

    localparam count_t DEFAULT_ATTEMPT_LIMIT = 32'd65536;
    localparam count_t DEFAULT_MAX_ADDR_VAL  = 32'd256;

    function automatic count_t sat_inc(input count_t v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/lfsr_key_sequencer_key_out_reg.sv
// One-entry valid/ready output register: a load always wins, otherwise a
// consumed entry empties, so load and consume may share a cycle.
module lfsr_key_sequencer_key_out_reg #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q;
    logic         valid_d;
    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    // Next-state selection for the held index.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Output register with asynchronous clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= {W{1'b0}};
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/lfsr_key_sequencer.sv
// Key sequencer: gates the LFSR, filters out-of-range indices and issues
// exactly num_keys indices per sweep, or aborts after an attempt limit.
module lfsr_key_sequencer
    import lfsr_key_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = 8,
    parameter count_t      MAX_ADDR_VAL  = DEFAULT_MAX_ADDR_VAL,
    parameter count_t      ATTEMPT_LIMIT = DEFAULT_ATTEMPT_LIMIT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [31:0]           num_keys,
    input  logic [31:0]           lfsr_out,
    output logic                  lfsr_enable,
    output logic [31:0]           lfsr_num_keys,
    output logic                  key_valid,
    input  logic                  key_ready,
    output logic [ADDR_WIDTH-1:0] key_index,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout,
    output logic [31:0]           issued_count
);

    state_e state_q;
    count_t nk_q;
    count_t sel_q;
    count_t att_q;
    count_t issued_q;
    logic   timeout_q;

    count_t nk_clamped;
    logic   fire;
    logic   load;

    assign nk_clamped = (num_keys > MAX_ADDR_VAL) ? MAX_ADDR_VAL : num_keys;
    assign fire       = key_valid && key_ready;

    // The stall term is combinational so a blocked consumer never loses a sample.
    assign lfsr_enable = (state_q == ST_RUN) && (!key_valid || key_ready) &&
                         (sel_q < nk_q) && (att_q < ATTEMPT_LIMIT);
    assign load        = lfsr_enable && (lfsr_out < nk_q);

    lfsr_key_sequencer_key_out_reg #(
        .W (ADDR_WIDTH)
    ) u_key_out_reg (
        .clk_i   (clk),
        .rst_i   (reset),
        .load_i  (load),
        .data_i  (lfsr_out[ADDR_WIDTH-1:0]),
        .ready_i (key_ready),
        .valid_o (key_valid),
        .data_o  (key_index)
    );

    // Sweep FSM with its counters and sticky abort flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            nk_q      <= 32'd0;
            sel_q     <= 32'd0;
            att_q     <= 32'd0;
            issued_q  <= 32'd0;
            timeout_q <= 1'b0;
        end else begin
            if (fire) begin
                issued_q <= sat_inc(issued_q);
            end
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        nk_q      <= nk_clamped;
                        sel_q     <= 32'd0;
                        att_q     <= 32'd0;
                        issued_q  <= 32'd0;
                        timeout_q <= 1'b0;
                        state_q   <= (nk_clamped == 32'd0) ? ST_FIN : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (lfsr_enable) begin
                        att_q <= sat_inc(att_q);
                        if (load) begin
                            sel_q <= sat_inc(sel_q);
                        end
                        // A selection that completes the sweep is never an abort.
                        if (load && (sel_q + 32'd1 >= nk_q)) begin
                            state_q <= ST_DRAIN;
                        end else if (att_q + 32'd1 >= ATTEMPT_LIMIT) begin
                            timeout_q <= 1'b1;
                            state_q   <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!key_valid || key_ready) begin
                        state_q <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign lfsr_num_keys = nk_q;
    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_FIN);
    assign timeout       = timeout_q;
    assign issued_count  = issued_q;

endmodule

// File: tb/tb_lfsr_key_sequencer.sv
// Directed bench: a sequence-level model predicts each sweep's issued list,
// attempt count and abort flag; one negedge process checks the DUTs.
module tb_lfsr_key_sequencer;
    import lfsr_key_sequencer_pkg::*;

    localparam int LIM = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, start_b;
    logic [31:0] num_keys, num_keys_b, lfsr_out, lfsr_out_b;
    logic        key_ready, key_ready_b;
    logic        lfsr_enable, key_valid, busy, done, timeout;
    logic        lfsr_enable_b, key_valid_b, busy_b, done_b, timeout_b;
    logic [31:0] lfsr_num_keys, issued_count, lfsr_num_keys_b, issued_count_b;
    logic [7:0]  key_index, key_index_b;

    always #5 clk = ~clk;

    lfsr_key_sequencer #(.ADDR_WIDTH(8), .MAX_ADDR_VAL(32'd256), .ATTEMPT_LIMIT(32'd16)) dut (
        .clk(clk), .reset(reset), .start(start), .num_keys(num_keys), .lfsr_out(lfsr_out),
        .lfsr_enable(lfsr_enable), .lfsr_num_keys(lfsr_num_keys), .key_valid(key_valid),
        .key_ready(key_ready), .key_index(key_index), .busy(busy), .done(done),
        .timeout(timeout), .issued_count(issued_count));

    lfsr_key_sequencer dut_b (
        .clk(clk), .reset(reset), .start(start_b), .num_keys(num_keys_b), .lfsr_out(lfsr_out_b),
        .lfsr_enable(lfsr_enable_b), .lfsr_num_keys(lfsr_num_keys_b), .key_valid(key_valid_b),
        .key_ready(key_ready_b), .key_index(key_index_b), .busy(busy_b), .done(done_b),
        .timeout(timeout_b), .issued_count(issued_count_b));

    // Stimulus-owned sweep description
    logic [31:0] seq [0:511];
    int          exp_list [0:255];
    int          lit_list [0:7];
    int          exp_n = 0, exp_att = 0, exp_nkc = 0, sweep_id = 0;
    logic        exp_to = 1'b0, lit_on = 1'b0, wd_expired = 1'b0, lfsr_restart = 1'b0;
    int          lit_n = 0, lit_att = 0, lit_len = 0;
    logic        lit_to = 1'b0;

    // Checker-owned
    int          n_cmp = 0, n_bad = 0;
    logic        adv = 1'b0, adv_b = 1'b0;

    // LFSR environment: advances only on cycles the DUT enabled it
    int ptr = 0, ptr_b = 0;
    initial begin
        lfsr_out = 32'd0;
        lfsr_out_b = 32'd0;
        forever begin
            @(posedge clk);
            #2;
            if (lfsr_restart) ptr = 0;
            else if (adv) ptr = ptr + 1;
            if (adv_b) ptr_b = ptr_b + 1;
            lfsr_out = seq[ptr % 512];
            lfsr_out_b = ptr_b;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Compare process
    initial begin
        int seen_id = 0, cyc_c = 0, hs_c = 0, att_c = 0, hs_b = 0;
        logic prev_stall = 1'b0, prev_hs = 1'b0, prev_done = 1'b0;
        logic [7:0] prev_idx = 8'd0;
        forever begin
            @(negedge clk);
            adv = lfsr_enable;
            adv_b = lfsr_enable_b;
            chk("watchdog", {31'd0, wd_expired}, 32'd0);
            if (sweep_id != seen_id) begin
                seen_id = sweep_id; cyc_c = 0; hs_c = 0; att_c = 0;
            end else begin
                cyc_c++;
            end
            if (reset) begin
                chk("rst_en", {31'd0, lfsr_enable}, 32'd0);
                chk("rst_valid", {31'd0, key_valid}, 32'd0);
                chk("rst_index", {24'd0, key_index}, 32'd0);
                chk("rst_busy", {31'd0, busy}, 32'd0);
                chk("rst_done", {31'd0, done}, 32'd0);
                chk("rst_timeout", {31'd0, timeout}, 32'd0);
                chk("rst_issued", issued_count, 32'd0);
                chk("rst_nk", lfsr_num_keys, 32'd0);
                chk("rst_b_busy", {31'd0, busy_b}, 32'd0);
                prev_stall = 1'b0; prev_hs = 1'b0; prev_done = 1'b0;
            end else begin
                if (lfsr_enable) att_c++;
                if (cyc_c == 1) begin
                    chk("c1_busy", {31'd0, busy}, 32'd1);
                    chk("c1_enable", {31'd0, lfsr_enable}, (exp_nkc != 0) ? 32'd1 : 32'd0);
                    chk("c1_done", {31'd0, done}, (exp_nkc == 0) ? 32'd1 : 32'd0);
                    chk("c1_timeout", {31'd0, timeout}, 32'd0);
                end
                if (busy) chk("nk_stable", lfsr_num_keys, exp_nkc);
                if (!busy) chk("idle_valid", {31'd0, key_valid}, 32'd0);
                if (key_valid && !key_ready) chk("stall_enable", {31'd0, lfsr_enable}, 32'd0);
                if (prev_stall) begin
                    chk("hold_valid", {31'd0, key_valid}, 32'd1);
                    chk("hold_index", {24'd0, key_index}, {24'd0, prev_idx});
                end
                if (key_valid && key_ready) begin
                    if (hs_c < exp_n) chk("issue_index", {24'd0, key_index}, exp_list[hs_c]);
                    else chk("extra_issue", hs_c, exp_n);
                    if (lit_on && hs_c < lit_len) chk("lit_index", {24'd0, key_index}, lit_list[hs_c]);
                    hs_c++;
                end
                if (done) begin
                    chk("n_issued", hs_c, exp_n);
                    chk("issued_count", issued_count, exp_n);
                    chk("timeout", {31'd0, timeout}, {31'd0, exp_to});
                    chk("attempts", att_c, exp_att);
                    chk("done_pulse", {31'd0, prev_done}, 32'd0);
                    if (exp_n > 0 && !exp_to) chk("done_latency", {31'd0, prev_hs}, 32'd1);
                    if (lit_on) begin
                        chk("lit_issued", issued_count, lit_n);
                        chk("lit_attempts", att_c, lit_att);
                        chk("lit_timeout", {31'd0, timeout}, {31'd0, lit_to});
                    end
                end
                if (busy_b) chk("big_nk", lfsr_num_keys_b, 32'd256);
                if (key_valid_b && key_ready_b) begin
                    chk("big_index", {24'd0, key_index_b}, {24'd0, hs_b[7:0]});
                    hs_b++;
                end
                if (done_b) begin
                    chk("big_hs", hs_b, 32'd256);
                    chk("big_issued", issued_count_b, 32'd256);
                    chk("big_timeout", {31'd0, timeout_b}, 32'd0);
                end
                prev_stall = key_valid && !key_ready;
                prev_idx = key_index;
                prev_hs = key_valid && key_ready;
                prev_done = done;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sequence-level model: walk the LFSR values in order under both limits
    task automatic prepare(input logic [31:0] nk);
        logic [31:0] nkc;
        int n, a;
        nkc = (nk > 32'd256) ? 32'd256 : nk;
        n = 0; a = 0;
        while (n < int'(nkc) && a < LIM) begin
            if (seq[a] < nkc) begin
                exp_list[n] = int'(seq[a]);
                n++;
            end
            a++;
        end
        exp_n = n; exp_att = a; exp_to = (n < int'(nkc)); exp_nkc = int'(nkc);
        sweep_id++;
        lfsr_restart = 1'b1;
        num_keys = nk;
        start = 1'b1;
    endtask

    task automatic sweep(input logic [31:0] nk, input int stall, input logic [15:0] rpat);
        int cnt, cyc;
        bit stalled;
        prepare(nk);
        key_ready = rpat[0];
        tick();
        start = 1'b0; lfsr_restart = 1'b0;
        num_keys = 32'hDEAD_BEEF;
        cnt = 0; cyc = 0; stalled = 0;
        while (!done && cyc < 600) begin
            if (stall > 0 && !stalled && key_valid) begin
                stalled = 1; cnt = stall;
            end
            if (cnt > 0) begin
                key_ready = 1'b0; cnt--;
            end else begin
                key_ready = rpat[cyc % 16];
            end
            tick();
            cyc++;
        end
        if (!done) wd_expired = 1'b1;
        tick();
        key_ready = 1'b1;
    endtask

    task automatic set_lit(input int n, input int att, input logic to, input int len,
                           input int l0, input int l1, input int l2, input int l3, input int l4);
        lit_on = 1'b1; lit_n = n; lit_att = att; lit_to = to; lit_len = len;
        lit_list[0] = l0; lit_list[1] = l1; lit_list[2] = l2; lit_list[3] = l3; lit_list[4] = l4;
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < 512; i++) seq[i] = i;
    endtask

    task automatic fill_const(input logic [31:0] v);
        for (int i = 0; i < 512; i++) seq[i] = v;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; start_b = 1'b0; num_keys = 32'd0; num_keys_b = 32'd0;
        key_ready = 1'b1; key_ready_b = 1'b1;
        fill_ramp();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        tick();

        // ramp, always ready
        set_lit(5, 5, 1'b0, 5, 0, 1, 2, 3, 4);
        sweep(32'd5, 0, 16'hFFFF);

        // out-of-range values interleaved
        fill_const(32'd31);
        seq[0] = 7; seq[1] = 6; seq[2] = 5; seq[3] = 2; seq[4] = 0;
        seq[5] = 7; seq[6] = 1; seq[7] = 3; seq[8] = 6; seq[9] = 4;
        set_lit(5, 10, 1'b0, 5, 2, 0, 1, 3, 4);
        sweep(32'd5, 0, 16'hFFFF);

        // consumer stalls for 10 cycles after the first valid
        fill_ramp();
        set_lit(5, 5, 1'b0, 5, 0, 1, 2, 3, 4);
        sweep(32'd5, 10, 16'hFFFF);

        // zero keys
        set_lit(0, 0, 1'b0, 0, 0, 0, 0, 0, 0);
        sweep(32'd0, 0, 16'hFFFF);

        // stuck LFSR aborts after the attempt limit
        fill_const(32'd200);
        set_lit(0, 16, 1'b1, 0, 0, 0, 0, 0, 0);
        sweep(32'd10, 0, 16'hFFFF);

        // next start clears timeout; duplicates forwarded; alternating ready
        fill_const(32'd31);
        seq[0] = 9; seq[1] = 2; seq[2] = 2; seq[3] = 1;
        set_lit(3, 4, 1'b0, 3, 2, 2, 1, 0, 0);
        sweep(32'd3, 0, 16'hAAAA);

        // model-only: mixed values, irregular ready, aborts with index held
        for (int i = 0; i < 512; i++) seq[i] = (i * 7 + 3) % 20;
        lit_on = 1'b0;
        sweep(32'd12, 0, 16'hF3B7);

        // reset while an index is held
        fill_ramp();
        lit_on = 1'b0;
        prepare(32'd5);
        key_ready = 1'b0;
        tick();
        start = 1'b0; lfsr_restart = 1'b0;
        tick(); tick();
        #1 reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        key_ready = 1'b1;
        tick();

        // fresh sweep after reset
        set_lit(5, 5, 1'b0, 5, 0, 1, 2, 3, 4);
        sweep(32'd5, 0, 16'hFFFF);
        lit_on = 1'b0;

        // clamp on the default-parameter instance
        num_keys_b = 32'd300;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        num_keys_b = 32'd0;
        for (int c = 0; c < 1000 && !done_b; c++) tick();
        if (!done_b) wd_expired = 1'b1;
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
